// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: PC, synchronous imem read issue, small instruction buffer, valid/ready to decode.
// Fetch latency is 2 cycles from issue to inst_valid; issue stalls when buffer plus in-flight read would overflow.
module inst_fetch_unit #(
  parameter int              AW       = 6,
  parameter int              DW       = 8,
  parameter int              DEPTH    = 2,
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [AW-1:0] imem_addr,
  output logic          imem_rd,
  input  logic [DW-1:0] imem_data,
  output logic [DW-1:0] inst,
  output logic [AW-1:0] inst_pc,
  output logic          inst_valid,
  input  logic          inst_ready,
  input  logic          jump_en,
  input  logic [AW-1:0] jump_addr,
  input  logic          halt,
  input  logic          resume,
  output logic          halted,
  output logic [AW-1:0] pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {RUN, HALTED} state_t;

  state_t state_q, state_d;

  logic [DW-1:0] buf_data [DEPTH];
  logic [AW-1:0] buf_pc   [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          inflight;
  logic [AW-1:0] inflight_pc;
  logic [AW-1:0] pc_q;
  logic          pop, push, issue;
  logic [CW:0]   occ;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Reset forces every handshake output low, even before the reset edge lands.
  assign inst_valid = (count != '0) & ~rst_n;
  assign inst       = inst_valid ? buf_data[rd_ptr] : '0;
  assign inst_pc    = inst_valid ? buf_pc[rd_ptr] : '0;
  assign halted     = (state_q == HALTED) & ~rst_n;
  assign pop        = inst_valid & inst_ready;
  assign push       = inflight & ~jump_en;

  // Occupancy after this cycle's pop, counting the read already in flight.
  assign occ   = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
  assign issue = (state_q == RUN) & ~halt & ~jump_en & ~rst_n & (occ < (CW + 1)'(DEPTH));

  assign imem_rd   = issue;
  assign imem_addr = pc_q;
  assign pc        = pc_q;

  always_comb begin
    state_d = state_q;
    if (!jump_en) begin
      if (halt)
        state_d = HALTED;
      else if (resume && state_q == HALTED)
        state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n)
      state_q <= RUN;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      pc_q        <= RESET_PC;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc_q        <= pc_q + AW'(1);
        inflight_pc <= pc_q;
      end
      if (jump_en) begin
        // A pop this cycle is still accepted; the flush then drops everything else.
        pc_q   <= jump_addr;
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push)
          wr_ptr <= ptr_inc(wr_ptr);
        if (pop)
          rd_ptr <= ptr_inc(rd_ptr);
        if (push && !pop)
          count <= count + CW'(1);
        else if (pop && !push)
          count <= count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n && push) begin
      buf_data[wr_ptr] <= imem_data;
      buf_pc[wr_ptr]   <= inflight_pc;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed timing scenarios plus a randomized run against a stream-level model.
module tb_inst_fetch_unit;

  logic       clk;
  logic       rst_n;
  logic [5:0] imem_addr;
  logic       imem_rd;
  logic [7:0] imem_data;
  logic [7:0] inst;
  logic [5:0] inst_pc;
  logic       inst_valid;
  logic       inst_ready;
  logic       jump_en;
  logic [5:0] jump_addr;
  logic       halt;
  logic       resume;
  logic       halted;
  logic [5:0] pc;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] mem [64];

  inst_fetch_unit #(.AW(6), .DW(8), .DEPTH(2), .RESET_PC(6'd0)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .imem_data(imem_data), .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .jump_en(jump_en), .jump_addr(jump_addr), .halt(halt),
    .resume(resume), .halted(halted), .pc(pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory: data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (imem_rd) imem_data <= mem[imem_addr];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_mem_linear;
    for (int i = 0; i < 64; i++) mem[i] = 8'(i + 16);
  endtask

  task automatic do_reset;
    rst_n = 1'b1; inst_ready = 1'b0; jump_en = 1'b0; jump_addr = '0; halt = 1'b0; resume = 1'b0;
    tick();
    rst_n = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b1; inst_ready = 1'b1; jump_en = 1'b1; jump_addr = 6'h15; halt = 1'b0; resume = 1'b1;
    tick();
    @(negedge clk);
    n_chk++; if (imem_rd !== 1'b0) $display("FAIL reset_rd: got %b want 0", imem_rd); else n_pass++;
    n_chk++; if (inst_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", inst_valid); else n_pass++;
    n_chk++; if (halted !== 1'b0) $display("FAIL reset_halted: got %b want 0", halted); else n_pass++;
    n_chk++; if (inst !== 8'h00 || inst_pc !== 6'd0) $display("FAIL reset_inst: got %h/%0d want 00/0", inst, inst_pc); else n_pass++;
    tick();
    rst_n = 1'b0; jump_en = 1'b0; resume = 1'b0; inst_ready = 1'b0;
    @(negedge clk);
    n_chk++; if (pc !== 6'd0) $display("FAIL reset_pc: got %0d want 0", pc); else n_pass++;
    n_chk++; if (imem_rd !== 1'b1 || imem_addr !== 6'd0) $display("FAIL reset_first_issue: got rd=%b addr=%0d want 1/0", imem_rd, imem_addr); else n_pass++;
    tick();
  endtask

  task automatic test_stream;
    do_reset();
    inst_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_chk++; if (imem_rd !== 1'b1 || imem_addr !== 6'(k)) $display("FAIL stream_issue c%0d: got rd=%b addr=%0d want 1/%0d", k, imem_rd, imem_addr, k); else n_pass++;
      n_chk++; if (inst_valid !== (k >= 2)) $display("FAIL stream_valid c%0d: got %b want %b", k, inst_valid, k >= 2); else n_pass++;
      if (k >= 2) begin
        n_chk++; if (inst !== 8'(k - 2 + 16) || inst_pc !== 6'(k - 2)) $display("FAIL stream_inst c%0d: got %h@%0d want %h@%0d", k, inst, inst_pc, 8'(k - 2 + 16), k - 2); else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_stall;
    do_reset();
    for (int k = 0; k < 13; k++) begin
      inst_ready = (k >= 7);
      @(negedge clk);
      if (k >= 2 && k <= 6) begin
        n_chk++; if (imem_rd !== 1'b0) $display("FAIL stall_rd c%0d: got %b want 0", k, imem_rd); else n_pass++;
        n_chk++; if (inst_valid !== 1'b1 || inst !== 8'h10 || inst_pc !== 6'd0) $display("FAIL stall_hold c%0d: got v=%b %h@%0d want 1 10@0", k, inst_valid, inst, inst_pc); else n_pass++;
      end
      if (k == 6) begin
        n_chk++; if (pc !== 6'd2) $display("FAIL stall_pc: got %0d want 2", pc); else n_pass++;
      end
      if (k >= 7) begin
        n_chk++; if (inst_valid !== 1'b1 || inst !== 8'(k - 7 + 16) || inst_pc !== 6'(k - 7)) $display("FAIL stall_release c%0d: got v=%b %h@%0d want 1 %h@%0d", k, inst_valid, inst, inst_pc, 8'(k - 7 + 16), k - 7); else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_wrap;
    logic [5:0] a;
    do_reset();
    inst_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      jump_en = (k == 0); jump_addr = 6'd60;
      @(negedge clk);
      if (k >= 1 && k <= 6) begin
        a = 6'(60 + k - 1);
        n_chk++; if (imem_addr !== a || imem_rd !== 1'b1) $display("FAIL wrap_issue c%0d: got %0d rd=%b want %0d", k, imem_addr, imem_rd, a); else n_pass++;
      end
      if (k == 5) begin
        n_chk++; if (pc !== 6'd0) $display("FAIL wrap_pc: got %0d want 0", pc); else n_pass++;
      end
      if (k >= 3) begin
        a = 6'(60 + k - 3);
        n_chk++; if (inst_valid !== 1'b1 || inst_pc !== a || inst !== 8'(a + 16)) $display("FAIL wrap_inst c%0d: got v=%b %h@%0d want %0d", k, inst_valid, inst, inst_pc, a); else n_pass++;
      end
      tick();
    end
    jump_en = 1'b0;
  endtask

  task automatic test_jump;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      inst_ready = (k >= 2);
      jump_en = (k == 2); jump_addr = 6'h20;
      @(negedge clk);
      if (k == 2) begin
        n_chk++; if (imem_rd !== 1'b0) $display("FAIL jump_cycle_rd: got %b want 0", imem_rd); else n_pass++;
      end
      if (k == 3) begin
        n_chk++; if (inst_valid !== 1'b0) $display("FAIL jump_flush: got %b want 0", inst_valid); else n_pass++;
        n_chk++; if (imem_rd !== 1'b1 || imem_addr !== 6'h20) $display("FAIL jump_target: got rd=%b addr=%h want 1/20", imem_rd, imem_addr); else n_pass++;
      end
      if (k == 4) begin
        n_chk++; if (inst_valid !== 1'b0) $display("FAIL jump_stale: got %b want 0 (pc %0d)", inst_valid, inst_pc); else n_pass++;
      end
      if (k >= 5) begin
        n_chk++; if (inst_valid !== 1'b1 || inst_pc !== 6'(32 + k - 5) || inst !== 8'(48 + k - 5)) $display("FAIL jump_deliver c%0d: got v=%b %h@%h want %h@%h", k, inst_valid, inst, inst_pc, 8'(48 + k - 5), 6'(32 + k - 5)); else n_pass++;
      end
      tick();
    end
    jump_en = 1'b0;
  endtask

  task automatic test_halt;
    do_reset();
    inst_ready = 1'b1;
    for (int k = 0; k < 14; k++) begin
      halt = (k == 5); resume = (k == 10);
      @(negedge clk);
      if (k == 5) begin
        n_chk++; if (imem_rd !== 1'b0 || imem_addr !== 6'd5) $display("FAIL halt_issue: got rd=%b addr=%0d want 0/5", imem_rd, imem_addr); else n_pass++;
      end
      if (k == 6) begin
        n_chk++; if (inst_valid !== 1'b1 || inst_pc !== 6'd4 || inst !== 8'h14) $display("FAIL halt_inflight: got v=%b %h@%0d want 14@4", inst_valid, inst, inst_pc); else n_pass++;
      end
      if (k >= 6 && k <= 10) begin
        n_chk++; if (halted !== 1'b1 || imem_rd !== 1'b0) $display("FAIL halt_hold c%0d: got halted=%b rd=%b want 1/0", k, halted, imem_rd); else n_pass++;
      end
      if (k == 7) begin
        n_chk++; if (inst_valid !== 1'b0) $display("FAIL halt_drain: got %b want 0", inst_valid); else n_pass++;
      end
      if (k == 11) begin
        n_chk++; if (halted !== 1'b0 || imem_rd !== 1'b1 || imem_addr !== 6'd5) $display("FAIL resume_issue: got h=%b rd=%b addr=%0d want 0/1/5", halted, imem_rd, imem_addr); else n_pass++;
      end
      if (k == 13) begin
        n_chk++; if (inst_valid !== 1'b1 || inst_pc !== 6'd5 || inst !== 8'h15) $display("FAIL resume_deliver: got v=%b %h@%0d want 15@5", inst_valid, inst, inst_pc); else n_pass++;
      end
      tick();
    end
    halt = 1'b0; resume = 1'b0;
  endtask

  task automatic test_halt_reset;
    inst_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      halt = (k == 0); resume = (k == 0); rst_n = (k == 2);
      @(negedge clk);
      if (k == 1) begin
        n_chk++; if (halted !== 1'b1 || imem_rd !== 1'b0) $display("FAIL both_halt: got h=%b rd=%b want 1/0", halted, imem_rd); else n_pass++;
      end
      if (k == 2) begin
        n_chk++; if (halted !== 1'b0 || inst_valid !== 1'b0 || imem_rd !== 1'b0) $display("FAIL midreset_out: got h=%b v=%b rd=%b want 0/0/0", halted, inst_valid, imem_rd); else n_pass++;
      end
      if (k == 3) begin
        n_chk++; if (halted !== 1'b0 || inst_valid !== 1'b0 || imem_rd !== 1'b1 || imem_addr !== 6'd0) $display("FAIL midreset_restart: got h=%b v=%b rd=%b addr=%0d", halted, inst_valid, imem_rd, imem_addr); else n_pass++;
      end
      if (k == 5) begin
        n_chk++; if (inst_valid !== 1'b1 || inst_pc !== 6'd0 || inst !== 8'h10) $display("FAIL midreset_first: got v=%b %h@%0d want 10@0", inst_valid, inst, inst_pc); else n_pass++;
      end
      tick();
    end
    halt = 1'b0; resume = 1'b0; rst_n = 1'b0;
  endtask

  // Model: delivered stream is consecutive addresses from the last redirect; halt only pauses it.
  task automatic test_random;
    int         deliv;
    logic [5:0] exp_pc;
    logic       exp_h, hold;
    logic [7:0] h_inst;
    logic [5:0] h_pc;
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    do_reset();
    deliv = 0; exp_pc = '0; exp_h = 1'b0; hold = 1'b0; h_inst = '0; h_pc = '0;
    for (int c = 0; c < 3000; c++) begin
      inst_ready = ($urandom_range(0, 3) != 0);
      jump_en    = ($urandom_range(0, 15) == 0);
      jump_addr  = 6'($urandom);
      halt       = ($urandom_range(0, 19) == 0);
      resume     = ($urandom_range(0, 5) == 0);
      @(negedge clk);
      n_chk++; if (halted !== exp_h) $display("FAIL rnd_halted c%0d: got %b want %b", c, halted, exp_h); else n_pass++;
      if (exp_h || halt || jump_en) begin
        n_chk++; if (imem_rd !== 1'b0) $display("FAIL rnd_noissue c%0d: got %b want 0", c, imem_rd); else n_pass++;
      end
      if (hold) begin
        n_chk++; if (inst_valid !== 1'b1 || inst !== h_inst || inst_pc !== h_pc) $display("FAIL rnd_stall c%0d: got v=%b %h@%0d want %h@%0d", c, inst_valid, inst, inst_pc, h_inst, h_pc); else n_pass++;
      end
      if (inst_valid && inst_ready) begin
        n_chk++; if (inst_pc !== exp_pc || inst !== mem[exp_pc]) $display("FAIL rnd_order c%0d: got %h@%0d want %h@%0d", c, inst, inst_pc, mem[exp_pc], exp_pc); else n_pass++;
        exp_pc = exp_pc + 6'd1;
        deliv++;
      end
      hold = inst_valid && !inst_ready && !jump_en;
      h_inst = inst; h_pc = inst_pc;
      if (jump_en) exp_pc = jump_addr;
      else if (halt) exp_h = 1'b1;
      else if (resume) exp_h = 1'b0;
      tick();
    end
    jump_en = 1'b0; halt = 1'b0; resume = 1'b0;
    n_chk++; if (deliv < 300) $display("FAIL rnd_throughput: got %0d deliveries want >= 300", deliv); else n_pass++;
  endtask

  initial begin
    rst_n = 1'b1; inst_ready = 1'b0; jump_en = 1'b0; jump_addr = '0; halt = 1'b0; resume = 1'b0;
    fill_mem_linear();
    test_reset();
    test_stream();
    test_stall();
    test_wrap();
    test_jump();
    test_halt();
    test_halt_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
